// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode constants: instruction width and opcode field.
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous FIFO of {instr, pc} entries; flush wins over push.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign do_pop = pop && (cnt_q != '0);
  assign head   = mem_q[rd_q];
  assign count  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem requests, instruction buffer, redirect, HALT.
// IFETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [OW-1:0]     occ;
  logic              pop, push, is_halt;

  assign instr_valid = count != '0;
  assign pop = instr_valid && instr_ready;

  // occupancy the FIFO will reach once the pending response lands
  assign occ = OW'(count) + OW'(inflight_q) - OW'(pop);

  assign imem_req = !rst && !halted_q && !redirect_valid
                 && (occ < OW'(FIFO_DEPTH));
  assign imem_addr = pc_q;

  assign push = inflight_q && !redirect_valid && !halted_q;
  assign is_halt = imem_rdata[OPCODE_MSB:OPCODE_LSB] == OP_HALT;

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = imem_req;
    halted_d   = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else begin
      if (imem_req) begin
        pc_d  = pc_q + 1'b1;
        tag_d = pc_q;
      end
      if (push && is_halt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_rdata, tag_q}),
    .head  (head),
    .count (count)
  );

  assign instr    = instr_valid ? head[EW-1:ADDR_W] : '0;
  assign instr_pc = instr_valid ? head[ADDR_W-1:0] : '0;
  assign halted   = halted_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (pop) fetched_q <= fetched_q + 1'b1;
      if (instr_ready && !instr_valid && !halted_q)
        bubbles_q <= bubbles_q + 1'b1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule
